// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   NOP_INSTR           : word loaded into IF/ID on flush or after halt
//   DEFAULT_HALT_OPCODE : opcode field (bits 31:26) that stops fetch
//   PC_STEP             : sequential PC increment in bytes
//   if_state_t          : fetch-control FSM states
package mips_pkg;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0000;
    localparam logic [5:0]  DEFAULT_HALT_OPCODE = 6'b111111;
    localparam logic [31:0] PC_STEP             = 32'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STEP   = 2'd1,
        HALTED = 2'd2
    } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory.
//   clk          : write clock
//   writeEnable  : synchronous write strobe
//   writeAddr    : word index for writes
//   writeData    : word to store
//   readAddr     : word index for the asynchronous read port
//   readData     : word at readAddr (combinational)
// The array has no reset, so program contents survive a pipeline reset.
// A read on the same edge as a write to that index sees the old word.
module instruction_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [31:0]       writeData,
    input  logic [ADDR_W-1:0] readAddr,
    output logic [31:0]       readData
);

    logic [31:0] memArray [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEnable) begin
            memArray[writeAddr] <= writeData;
        end
    end

    assign readData = memArray[readAddr];

endmodule

// File: rtl/instruction_fetch.sv
// Pipeline IF stage: PC, instruction memory and the IF/ID register.
//   clk, rst              : clock, asynchronous active-high reset
//   inPC_write            : PC update enable (hazard unit)
//   inIF_ID_write         : IF/ID update enable (hazard unit)
//   inPC_src              : redirect PC to inBranchAddress (word aligned)
//   inBranchAddress       : redirect target, byte address
//   inFlush               : load NOP into IF/ID this edge
//   inStepMode, inStep    : debug single-step mode / step request (edge detected)
//   inImemWrite/Addr/Data : instruction memory load port
//   outInstruction        : IF/ID instruction
//   outInstructionAddress : IF/ID PC+4
//   outPC                 : current PC
//   outHalted             : HALT word fetched, fetch stopped until reset
// Flow control: there is no valid/ready pair; the hazard unit's enables are
// plain level qualifiers sampled each rising edge, and a stage holds its
// contents on any edge where its enable (or the advance condition) is low.
// IMEM_ADDR_W must equal clog2(IMEM_DEPTH).
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH  = 256,
    parameter int          IMEM_ADDR_W = 8,
    parameter logic [5:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inPC_write,
    input  logic                   inIF_ID_write,
    input  logic                   inPC_src,
    input  logic [31:0]            inBranchAddress,
    input  logic                   inFlush,
    input  logic                   inStepMode,
    input  logic                   inStep,
    input  logic                   inImemWrite,
    input  logic [IMEM_ADDR_W-1:0] inImemAddr,
    input  logic [31:0]            inImemData,
    output logic [31:0]            outInstruction,
    output logic [31:0]            outInstructionAddress,
    output logic [31:0]            outPC,
    output logic                   outHalted
);

    if_state_t        state;
    if_state_t        nextState;
    logic             stepQ;
    logic             stepEdge;
    logic             adv;
    logic             halted;
    logic [31:0]      pcReg;
    logic [31:0]      pcPlus4;
    logic [31:0]      branchTarget;
    logic [31:0]      fetchWord;
    logic             loadFetch;
    logic             haltFetch;

    // Index wraps naturally because only IMEM_ADDR_W bits of the PC are used.
    instruction_memory #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (IMEM_ADDR_W)
    ) u_imem (
        .clk         (clk),
        .writeEnable (inImemWrite),
        .writeAddr   (inImemAddr),
        .writeData   (inImemData),
        .readAddr    (pcReg[IMEM_ADDR_W+1:2]),
        .readData    (fetchWord)
    );

    assign pcPlus4      = pcReg + PC_STEP;
    assign branchTarget = inBranchAddress & ~32'h3;
    assign stepEdge     = inStep & ~stepQ;

    // A real (unflushed) load of a HALT word is what stops the stage.
    assign loadFetch = adv && inIF_ID_write && !inFlush;
    assign haltFetch = loadFetch && (fetchWord[31:26] == HALT_OPCODE);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            stepQ <= 1'b0;
        end else begin
            state <= nextState;
            stepQ <= inStep;
        end
    end

    // FSM: next-state logic; a halt fetch wins over a mode change.
    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (inStepMode)  nextState = STEP;
            STEP:    if (!inStepMode) nextState = RUN;
            HALTED:  nextState = HALTED;
            default: nextState = RUN;
        endcase
        if (haltFetch) begin
            nextState = HALTED;
        end
    end

    // FSM: outputs
    always_comb begin
        adv    = 1'b0;
        halted = 1'b0;
        case (state)
            RUN:     adv = 1'b1;
            STEP:    adv = stepEdge;
            HALTED:  halted = 1'b1;
            default: adv = 1'b0;
        endcase
    end

    assign outHalted = halted;
    assign outPC     = pcReg;

    // PC: redirect beats stall and pending step; frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcReg <= 32'h0;
        end else if (inPC_src && !halted) begin
            pcReg <= branchTarget;
        end else if (adv && inPC_write) begin
            pcReg <= pcPlus4;
        end
    end

    // IF/ID: flush beats the hazard-unit hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outInstruction        <= 32'h0;
            outInstructionAddress <= 32'h0;
        end else if (inFlush || halted) begin
            outInstruction        <= NOP_INSTR;
            outInstructionAddress <= pcPlus4;
        end else if (adv && inIF_ID_write) begin
            outInstruction        <= fetchWord;
            outInstructionAddress <= pcPlus4;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        inPC_write;
    logic        inIF_ID_write;
    logic        inPC_src;
    logic [31:0] inBranchAddress;
    logic        inFlush;
    logic        inStepMode;
    logic        inStep;
    logic        inImemWrite;
    logic [7:0]  inImemAddr;
    logic [31:0] inImemData;
    logic [31:0] outInstruction;
    logic [31:0] outInstructionAddress;
    logic [31:0] outPC;
    logic        outHalted;

    int assertCount;
    int failCount;

    // scoreboard entries: {instruction, instruction address, pc}
    logic [95:0] exp_q[$];

    instruction_fetch dut (
        .clk                   (clk),
        .rst                   (rst),
        .inPC_write            (inPC_write),
        .inIF_ID_write         (inIF_ID_write),
        .inPC_src              (inPC_src),
        .inBranchAddress       (inBranchAddress),
        .inFlush               (inFlush),
        .inStepMode            (inStepMode),
        .inStep                (inStep),
        .inImemWrite           (inImemWrite),
        .inImemAddr            (inImemAddr),
        .inImemData            (inImemData),
        .outInstruction        (outInstruction),
        .outInstructionAddress (outInstructionAddress),
        .outPC                 (outPC),
        .outHalted             (outHalted)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        inImemWrite = 1'b1;
        inImemAddr  = a;
        inImemData  = d;
        tick();
        inImemWrite = 1'b0;
    endtask

    task automatic set_idle();
        inPC_write      = 1'b1;
        inIF_ID_write   = 1'b1;
        inPC_src        = 1'b0;
        inBranchAddress = 32'h0;
        inFlush         = 1'b0;
        inStepMode      = 1'b0;
        inStep          = 1'b0;
    endtask

    // Hold reset over one edge, then release between edges.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_sb(input string name);
        logic [95:0] e;
        if (exp_q.size() == 0) begin
            assertCount++;
            failCount++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            assertCount++;
            if ({outInstruction, outInstructionAddress, outPC} !== e) begin
                failCount++;
                $display("FAIL %s: got instr=%h addr=%h pc=%h expected instr=%h addr=%h pc=%h",
                         name, outInstruction, outInstructionAddress, outPC,
                         e[95:64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        inImemWrite = 1'b0;
        inImemAddr  = 8'h0;
        inImemData  = 32'h0;
        rst = 1'b1;
        tick();
        // program loaded while reset is held
        load_word(8'd0,  32'h2001_0005);
        load_word(8'd1,  32'h2002_0007);
        load_word(8'd2,  32'h0022_1820);
        load_word(8'd3,  32'hFC00_0000);
        load_word(8'd4,  32'h2005_0004);
        load_word(8'd16, 32'h1234_5678);
        assertCount++;
        if ({outInstruction, outInstructionAddress, outPC, outHalted} !== 97'h0) begin
            failCount++;
            $display("FAIL reset_state: got instr=%h addr=%h pc=%h halted=%b expected all zero",
                     outInstruction, outInstructionAddress, outPC, outHalted);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential_fetch();
        exp_q.push_back({32'h2001_0005, 32'h4, 32'h4});
        exp_q.push_back({32'h2002_0007, 32'h8, 32'h8});
        tick();
        check_sb("seq_edge1");
        tick();
        check_sb("seq_edge2");
    endtask

    task automatic test_stall();
        inPC_write    = 1'b0;
        inIF_ID_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({32'h2002_0007, 32'h8, 32'h8});
            tick();
            check_sb("stall_hold");
        end
        inPC_write    = 1'b1;
        inIF_ID_write = 1'b1;
        exp_q.push_back({32'h0022_1820, 32'hC, 32'hC});
        tick();
        check_sb("stall_release");
    endtask

    task automatic test_branch_flush();
        // PC=0xC points at the HALT word: flushing must also discard it.
        inPC_src        = 1'b1;
        inBranchAddress = 32'h43;
        inFlush         = 1'b1;
        inPC_write      = 1'b0;
        exp_q.push_back({32'h0, 32'h10, 32'h40});
        tick();
        check_sb("branch_edge");
        assertCount++;
        if (outHalted !== 1'b0) begin
            failCount++;
            $display("FAIL branch_halt_discard: got halted=%b expected 0", outHalted);
        end
        set_idle();
        exp_q.push_back({32'h1234_5678, 32'h44, 32'h44});
        tick();
        check_sb("branch_target_fetch");
    endtask

    task automatic test_single_step();
        set_idle();
        inStepMode = 1'b1;
        rst = 1'b1;
        tick();
        load_word(8'd3, 32'h2004_0003);
        rst = 1'b0;
        // first edge still in RUN, then parked in STEP
        tick();
        tick();
        assertCount++;
        if (outPC !== 32'h4) begin
            failCount++;
            $display("FAIL step_enter: got pc=%h expected %h", outPC, 32'h4);
        end
        inStep = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        exp_q.push_back({32'h2002_0007, 32'h8, 32'h8});
        check_sb("step_held_high");
        for (int i = 0; i < 3; i++) begin
            inStep = 1'b0;
            tick();
            inStep = 1'b1;
            tick();
        end
        exp_q.push_back({32'h2005_0004, 32'h14, 32'h14});
        check_sb("step_toggle3");
        inStep     = 1'b0;
        inStepMode = 1'b0;
    endtask

    task automatic test_halt();
        set_idle();
        rst = 1'b1;
        tick();
        load_word(8'd3, 32'hFC00_0000);
        rst = 1'b0;
        tick();
        tick();
        tick();
        exp_q.push_back({32'hFC00_0000, 32'h10, 32'h10});
        tick();
        check_sb("halt_fetch");
        assertCount++;
        if (outHalted !== 1'b1) begin
            failCount++;
            $display("FAIL halt_flag: got halted=%b expected 1", outHalted);
        end
        exp_q.push_back({32'h0, 32'h14, 32'h10});
        tick();
        check_sb("halt_nop");
        inPC_src        = 1'b1;
        inBranchAddress = 32'h80;
        exp_q.push_back({32'h0, 32'h14, 32'h10});
        tick();
        check_sb("halt_ignores_branch");
        inPC_src = 1'b0;
    endtask

    task automatic test_halt_flushed();
        set_idle();
        do_reset();
        tick();
        tick();
        tick();
        inFlush = 1'b1;
        exp_q.push_back({32'h0, 32'h10, 32'h10});
        tick();
        check_sb("halt_flushed_edge");
        assertCount++;
        if (outHalted !== 1'b0) begin
            failCount++;
            $display("FAIL halt_flushed_flag: got halted=%b expected 0", outHalted);
        end
        inFlush = 1'b0;
        exp_q.push_back({32'h2005_0004, 32'h14, 32'h14});
        tick();
        check_sb("halt_flushed_next");
    endtask

    task automatic test_midrun_reset();
        set_idle();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        assertCount++;
        if (outHalted !== 1'b1) begin
            failCount++;
            $display("FAIL midrun_pre_halted: got halted=%b expected 1", outHalted);
        end
        #2;
        rst = 1'b1;
        #1;
        assertCount++;
        if ({outInstruction, outPC, outHalted} !== 65'h0) begin
            failCount++;
            $display("FAIL midrun_async_reset: got instr=%h pc=%h halted=%b expected zero",
                     outInstruction, outPC, outHalted);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back({32'h2001_0005, 32'h4, 32'h4});
        tick();
        check_sb("midrun_mem_intact");
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_branch_flush();
        test_single_step();
        test_halt();
        test_halt_flushed();
        test_midrun_reset();
        assertCount++;
        if (exp_q.size() != 0) begin
            failCount++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
